// File: rtl/sram_port_arbiter.sv
// rtl/sram_port_arbiter.sv - two-port round-robin arbiter in front of one SRAM controller
//
// Purpose: shares a single SRAM controller between a data-memory port (port 0)
// and an instruction-refill port (port 1). The winning request's opcode,
// address and write data are captured at grant, and the SRAM side is driven
// from those captured copies until the controller reports completion.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   pN_rd_en / pN_wr_en       requester read / write request, held until pN_ready
//   pN_addr / pN_wdata        requester address / store value
//   pN_rdata                  read data back to requester
//   pN_ready                  stall signal to requester (0 = freeze)
//   sram_rd_en / sram_wr_en   enables to the SRAM controller
//   sram_addr / sram_wdata    address / store value to the SRAM controller
//   sram_rdata                64-bit line from the SRAM controller
//   sram_ready                controller ready, low while an access is in progress
module sram_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int RDATA_W = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               p0_rd_en,
  input  logic               p0_wr_en,
  input  logic [ADDR_W-1:0]  p0_addr,
  input  logic [DATA_W-1:0]  p0_wdata,
  output logic [RDATA_W-1:0] p0_rdata,
  output logic               p0_ready,
  input  logic               p1_rd_en,
  input  logic               p1_wr_en,
  input  logic [ADDR_W-1:0]  p1_addr,
  input  logic [DATA_W-1:0]  p1_wdata,
  output logic [RDATA_W-1:0] p1_rdata,
  output logic               p1_ready,
  output logic               sram_rd_en,
  output logic               sram_wr_en,
  output logic [ADDR_W-1:0]  sram_addr,
  output logic [DATA_W-1:0]  sram_wdata,
  input  logic [RDATA_W-1:0] sram_rdata,
  input  logic               sram_ready
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY0 = 2'd1,
    BUSY1 = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                last_q, last_d;
  logic                op_wr_q, op_wr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                seen_low_q, seen_low_d;
  logic [RDATA_W-1:0]  rdata0_q, rdata0_d;
  logic [RDATA_W-1:0]  rdata1_q, rdata1_d;

  logic req0, req1;
  logic busy;
  logic done;
  logic done0, done1;

  assign req0 = p0_rd_en | p0_wr_en;
  assign req1 = p1_rd_en | p1_wr_en;
  assign busy = (state_q == BUSY0) || (state_q == BUSY1);

  // Completion needs a low-then-high on sram_ready within the access, so a
  // controller that drops ready one cycle after the enable is not mistaken
  // for an instant completion.
  assign done  = busy & sram_ready & seen_low_q;
  assign done0 = (state_q == BUSY0) & done;
  assign done1 = (state_q == BUSY1) & done;

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    op_wr_d    = op_wr_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    seen_low_d = seen_low_q;
    rdata0_d   = rdata0_q;
    rdata1_d   = rdata1_q;

    case (state_q)
      IDLE: begin
        // last_q == 1 means port 1 was served last, so port 0 wins a tie.
        if (req0 && (!req1 || last_q)) begin
          state_d    = BUSY0;
          op_wr_d    = p0_wr_en;
          addr_d     = p0_addr;
          wdata_d    = p0_wdata;
          seen_low_d = 1'b0;
        end else if (req1) begin
          state_d    = BUSY1;
          op_wr_d    = p1_wr_en;
          addr_d     = p1_addr;
          wdata_d    = p1_wdata;
          seen_low_d = 1'b0;
        end
      end

      BUSY0, BUSY1: begin
        if (!sram_ready) begin
          seen_low_d = 1'b1;
        end
        if (done) begin
          if (!op_wr_q) begin
            if (state_q == BUSY0) begin
              rdata0_d = sram_rdata;
            end else begin
              rdata1_d = sram_rdata;
            end
          end
          last_d  = (state_q == BUSY1);
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      last_q     <= 1'b1;
      op_wr_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      seen_low_q <= 1'b0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      op_wr_q    <= op_wr_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      seen_low_q <= seen_low_d;
      rdata0_q   <= rdata0_d;
      rdata1_q   <= rdata1_d;
    end
  end

  // SRAM side comes straight from state and captured registers, so the
  // enables appear the cycle after the request is sampled.
  assign sram_rd_en = busy & ~op_wr_q;
  assign sram_wr_en = busy & op_wr_q;
  assign sram_addr  = addr_q;
  assign sram_wdata = wdata_q;

  assign p0_ready = ~req0 | done0;
  assign p1_ready = ~req1 | done1;

  // Read data is forwarded in the completion cycle, then held in the port's register.
  assign p0_rdata = (done0 & ~op_wr_q) ? sram_rdata : rdata0_q;
  assign p1_rdata = (done1 & ~op_wr_q) ? sram_rdata : rdata1_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb/tb_sram_port_arbiter.sv - scoreboard bench for sram_port_arbiter
module tb_sram_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        p0_rd_en, p0_wr_en, p1_rd_en, p1_wr_en;
  logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
  logic [63:0] p0_rdata, p1_rdata;
  logic        p0_ready, p1_ready;
  logic        sram_rd_en, sram_wr_en;
  logic [31:0] sram_addr, sram_wdata;
  logic [63:0] sram_rdata = 64'd0;
  logic        sram_ready = 1'b1;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sram_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RDATA_W(64)) dut (
    .clk(clk), .rst(rst),
    .p0_rd_en(p0_rd_en), .p0_wr_en(p0_wr_en), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_rdata(p0_rdata), .p0_ready(p0_ready),
    .p1_rd_en(p1_rd_en), .p1_wr_en(p1_wr_en), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_rdata(p1_rdata), .p1_ready(p1_ready),
    .sram_rd_en(sram_rd_en), .sram_wr_en(sram_wr_en), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata), .sram_ready(sram_ready)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] rdata_fn(input logic [31:0] a);
    return (a == 32'h100) ? 64'hDEAD_BEEF_0123_4567 : {a, ~a};
  endfunction

  // SRAM controller model: ready drops the cycle after the enable is seen,
  // stays low for lat cycles, then one completion cycle with data.
  int   lat    = 2;
  int   cnt    = 0;
  logic active = 1'b0;
  logic fin    = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      sram_ready <= 1'b1;
      active     <= 1'b0;
      fin        <= 1'b0;
    end else if (fin) begin
      fin        <= 1'b0;
      sram_rdata <= 64'h0BAD_0BAD_0BAD_0BAD;
    end else if (!active && (sram_rd_en || sram_wr_en)) begin
      active     <= 1'b1;
      cnt        <= lat;
      sram_ready <= 1'b0;
    end else if (active) begin
      if (cnt <= 1) begin
        sram_ready <= 1'b1;
        sram_rdata <= rdata_fn(sram_addr);
        active     <= 1'b0;
        fin        <= 1'b1;
      end else begin
        cnt <= cnt - 1;
      end
    end
  end

  typedef struct {
    int          port;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  txn_t        exp_q[$];
  txn_t        cur;
  logic        cur_active = 1'b0;
  logic        prev_en    = 1'b0;
  logic [63:0] exp_rd0    = 64'd0;
  logic [63:0] exp_rd1    = 64'd0;
  int          gap        = 0;
  logic        gap_mode   = 1'b0;
  logic        gap_armed  = 1'b0;
  logic        mon_en, dn0, dn1;

  task automatic push(input int port, input logic wr, input logic [31:0] a, input logic [31:0] d);
    txn_t t;
    t.port  = port;
    t.wr    = wr;
    t.addr  = a;
    t.wdata = d;
    exp_q.push_back(t);
  endtask

  always @(negedge clk) begin
    if (rst) begin
      cur_active = 1'b0;
      prev_en    = 1'b0;
      exp_rd0    = 64'd0;
      exp_rd1    = 64'd0;
      gap        = 0;
    end else begin
      mon_en = sram_rd_en | sram_wr_en;
      check("en_mutex", 64'(sram_rd_en & sram_wr_en), 64'd0);
      if (mon_en && !prev_en) begin
        if (gap_mode) begin
          if (gap_armed) check("idle_gap", 64'(gap), 64'd1);
          gap_armed = 1'b1;
        end
        check("sb_nonempty", 64'(exp_q.size() > 0), 64'd1);
        if (exp_q.size() > 0) begin
          cur        = exp_q.pop_front();
          cur_active = 1'b1;
        end
      end
      if (mon_en) gap = 0;
      else        gap++;
      if (cur_active) begin
        check("sram_addr",  64'(sram_addr),  64'(cur.addr));
        check("sram_wdata", 64'(sram_wdata), 64'(cur.wdata));
        check("sram_wr_en", 64'(sram_wr_en), 64'(cur.wr));
        check("sram_rd_en", 64'(sram_rd_en), 64'(!cur.wr));
      end
      dn0 = cur_active && fin && (cur.port == 0);
      dn1 = cur_active && fin && (cur.port == 1);
      check("p0_ready", 64'(p0_ready), 64'(!(p0_rd_en | p0_wr_en) | dn0));
      check("p1_ready", 64'(p1_ready), 64'(!(p1_rd_en | p1_wr_en) | dn1));
      check("p0_rdata", p0_rdata, (dn0 && !cur.wr) ? rdata_fn(cur.addr) : exp_rd0);
      check("p1_rdata", p1_rdata, (dn1 && !cur.wr) ? rdata_fn(cur.addr) : exp_rd1);
      if (dn0 && !cur.wr) exp_rd0 = rdata_fn(cur.addr);
      if (dn1 && !cur.wr) exp_rd1 = rdata_fn(cur.addr);
      if (cur_active && fin) cur_active = 1'b0;
      prev_en = mon_en;
    end
  end

  // Raises a request immediately, holds it through n completions, then drops it.
  task automatic drive_port(input int port, input logic rd, input logic wr,
                            input logic [31:0] a, input logic [31:0] d, input int n);
    int   done_cnt = 0;
    int   cyc      = 0;
    logic rdy;
    if (port == 0) begin
      p0_rd_en = rd; p0_wr_en = wr; p0_addr = a; p0_wdata = d;
    end else begin
      p1_rd_en = rd; p1_wr_en = wr; p1_addr = a; p1_wdata = d;
    end
    while (done_cnt < n && cyc < 400) begin
      @(negedge clk);
      cyc++;
      rdy = (port == 0) ? p0_ready : p1_ready;
      if (!rst && rdy) done_cnt++;
    end
    check($sformatf("p%0d_timeout", port), 64'(done_cnt < n), 64'd0);
    @(posedge clk);
    #1;
    if (port == 0) begin
      p0_rd_en = 1'b0; p0_wr_en = 1'b0;
    end else begin
      p1_rd_en = 1'b0; p1_wr_en = 1'b0;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    p0_rd_en = 1'b0; p0_wr_en = 1'b0; p0_addr = '0; p0_wdata = '0;
    p1_rd_en = 1'b0; p1_wr_en = 1'b0; p1_addr = '0; p1_wdata = '0;

    // Reset with both ports requesting, first grant to port 0.
    lat = 2;
    push(0, 1'b0, 32'h1000, 32'h0);
    push(1, 1'b0, 32'h2000, 32'h0);
    fork
      drive_port(0, 1'b1, 1'b0, 32'h1000, 32'h0, 1);
      drive_port(1, 1'b1, 1'b0, 32'h2000, 32'h0, 1);
      begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_rd_en",    64'(sram_rd_en), 64'd0);
        check("rst_wr_en",    64'(sram_wr_en), 64'd0);
        check("rst_addr",     64'(sram_addr),  64'd0);
        check("rst_p0_ready", 64'(p0_ready),   64'd0);
        check("rst_p1_ready", 64'(p1_ready),   64'd0);
        check("rst_p0_rdata", p0_rdata,        64'd0);
        check("rst_p1_rdata", p1_rdata,        64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
      end
    join
    repeat (2) @(posedge clk);
    #1;

    // Port 0 alone reads 0x100 with four low-ready cycles.
    lat = 4;
    push(0, 1'b0, 32'h100, 32'h0);
    fork
      drive_port(0, 1'b1, 1'b0, 32'h100, 32'h0, 1);
      begin
        @(negedge clk);
        check("lat_idle_rd_en", 64'(sram_rd_en), 64'd0);
        @(negedge clk);
        check("lat_busy_rd_en", 64'(sram_rd_en), 64'd1);
      end
    join
    repeat (2) @(posedge clk);
    #1;

    // Port 0 asserts rd_en and wr_en together: treated as a write.
    push(0, 1'b1, 32'h80, 32'h1234_5678);
    drive_port(0, 1'b1, 1'b1, 32'h80, 32'h1234_5678, 1);
    repeat (2) @(posedge clk);
    #1;

    // Port 1 write; requester inputs change while waiting.
    push(1, 1'b1, 32'h44, 32'hCAFE_F00D);
    fork
      drive_port(1, 1'b0, 1'b1, 32'h44, 32'hCAFE_F00D, 1);
      begin
        repeat (3) @(posedge clk);
        #1;
        p1_wdata = 32'h0;
        p1_addr  = 32'h0;
      end
    join
    repeat (2) @(posedge clk);
    #1;

    // Continuous requests from both ports alternate with one idle cycle.
    lat = 2;
    for (int i = 0; i < 3; i++) begin
      push(0, 1'b0, 32'h10, 32'h0);
      push(1, 1'b0, 32'h20, 32'h0);
    end
    gap_mode  = 1'b1;
    gap_armed = 1'b0;
    fork
      drive_port(0, 1'b1, 1'b0, 32'h10, 32'h0, 3);
      drive_port(1, 1'b1, 1'b0, 32'h20, 32'h0, 3);
    join
    gap_mode = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset in the middle of a port 1 access; p1 is re-arbitrated, p0 wins the tie.
    lat = 6;
    push(1, 1'b0, 32'h200, 32'h0);
    fork
      drive_port(1, 1'b1, 1'b0, 32'h200, 32'h0, 1);
      begin
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        push(0, 1'b0, 32'h300, 32'h0);
        push(1, 1'b0, 32'h200, 32'h0);
        @(posedge clk);
        @(negedge clk);
        check("mid_rst_rd_en",    64'(sram_rd_en), 64'd0);
        check("mid_rst_wr_en",    64'(sram_wr_en), 64'd0);
        check("mid_rst_addr",     64'(sram_addr),  64'd0);
        check("mid_rst_p0_rdata", p0_rdata,        64'd0);
        check("mid_rst_p1_rdata", p1_rdata,        64'd0);
        check("mid_rst_p1_ready", 64'(p1_ready),   64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        drive_port(0, 1'b1, 1'b0, 32'h300, 32'h0, 1);
      end
    join
    repeat (3) @(posedge clk);
    check("sb_drained", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Shares the single SRAM controller between two requesters:
  - Port 0: data memory, the cache controller's miss/write path.
  - Port 1: instruction fetch refill.
- Round-robin arbitration. Each granted transaction's opcode, address and write data are latched at grant. The SRAM side is driven from those registers until the SRAM controller completes.
- Each port gets the same stall-style `ready` signal the pipeline already uses: `ready` low means freeze.

Parameters:
- ADDR_W, 32, requester/SRAM address width
- DATA_W, 32, write data width
- RDATA_W, 64, read data width (SRAM controller returns a 64-bit line)

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- p0_rd_en  input  1  port 0 read request, held until p0_ready
- p0_wr_en  input  1  port 0 write request, held until p0_ready
- p0_addr  input  ADDR_W  port 0 address
- p0_wdata  input  DATA_W  port 0 store value
- p0_rdata  output  RDATA_W  port 0 read data
- p0_ready  output  1  port 0 not stalled
- p1_rd_en, p1_wr_en, p1_addr, p1_wdata, p1_rdata, p1_ready: same as port 0, for port 1
- sram_rd_en  output  1  read enable to SRAM controller
- sram_wr_en  output  1  write enable to SRAM controller
- sram_addr  output  ADDR_W  address to SRAM controller
- sram_wdata  output  DATA_W  store value to SRAM controller
- sram_rdata  input  RDATA_W  read data from SRAM controller
- sram_ready  input  1  SRAM controller ready: low while an access is in progress

Behaviour:
- Definitions:
  - reqN = pN_rd_en | pN_wr_en.
  - If a port asserts both rd_en and wr_en, the transaction is a write; rd_en is ignored for that transaction.
- States: IDLE, BUSY0, BUSY1.
- Registers: state; last (last-served port); op_wr, addr_q, wdata_q; seen_low; rdata0_q, rdata1_q.
- Reset (any cycle, including mid-transaction):
  - state=IDLE, last=1 (port 0 wins the first tie), seen_low=0.
  - addr_q, wdata_q, op_wr, rdata0_q, rdata1_q all 0.
  - Outputs: sram_rd_en=0, sram_wr_en=0, sram_addr=0, sram_wdata=0, p0_rdata=0, p1_rdata=0.
  - pN_ready = !reqN (combinational, so it is 1 when that port is idle).
  - An in-flight SRAM access is abandoned; no completion is reported.
- IDLE:
  - Only req0 → BUSY0. Only req1 → BUSY1.
  - Both → the port != last.
  - On grant, latch that port's op (wr_en), addr and wdata; clear seen_low.
- BUSYn:
  - sram_wr_en = op_wr, sram_rd_en = !op_wr, sram_addr = addr_q, sram_wdata = wdata_q.
  - SRAM enables are registered: request sampled in cycle N, enable visible in cycle N+1.
  - seen_low is set in any BUSY cycle with sram_ready=0.
  - Completion cycle = BUSY cycle with sram_ready=1 and (seen_low=1 or sram_ready was sampled low in this same cycle's first-busy check). Implement as done = sram_ready & seen_low. This is insensitive to whether the controller drops ready combinationally or one cycle late.
  - On done:
    - rdataN_q <= sram_rdata if op was a read.
    - last <= n; state <= IDLE. There is always one IDLE cycle between transactions.
- ready (combinational):
  - pN_ready = !reqN | (state==BUSYn & done).
  - A requesting port that is not granted, or is granted but not done, sees ready=0.
- rdata (combinational):
  - pN_rdata = sram_rdata in port N's done cycle when its op is a read; otherwise rdataN_q.
- Requester rules:
  - Changes to addr/wdata/op while waiting have no effect on a granted transaction; the latched copy is used.
  - Dropping a request after grant does not cancel it. The SRAM access finishes; the result is discarded except for the rdata update.
- Starvation: under continuous requests from both ports, grants strictly alternate, so each port waits at most one foreign transaction plus one IDLE cycle.
- Never assert sram_rd_en and sram_wr_en together. Both are 0 in IDLE.

Test Plan:
- Reset held 3 cycles, with p0/p1 both requesting → sram_rd_en=sram_wr_en=0, p0_ready=p1_ready=0; after release, first grant goes to port 0.
- Port 0 alone reads addr 0x100; SRAM model holds ready low 4 cycles then returns 64'hDEAD_BEEF_0123_4567 → sram_rd_en high from cycle after request until done; p0_ready=1 and p0_rdata=DEAD_BEEF_0123_4567 in done cycle only; p1_ready stays 1.
- Both ports read continuously (p0 addr 0x10, p1 addr 0x20) for 6 transactions → sram_addr sequence 0x10,0x20,0x10,0x20,0x10,0x20 with one IDLE cycle between each.
- Port 1 writes 32'hCAFEF00D to 0x44, then changes p1_wdata to 0 while waiting → sram_wdata stays CAFEF00D for the whole access.
- Port 0 asserts rd_en and wr_en together → sram_wr_en=1, sram_rd_en=0; p0_rdata unchanged.
- rst asserted mid-BUSY1 → next cycle state IDLE with enables 0 and rdata regs 0; a pending p1 request is re-arbitrated and port 0 wins a tie.
